id_ex_pipe: RTL and testbench

ID→EX pipeline register for the 5-stage RV32I core, sitting between `id_stage` and the execute stage. It captures decoded operands, immediate and control from ID. It detects load-use hazards and inserts a bubble while stalling IF/ID. It precomputes registered forwarding selects for EX, applies branch flushes and memory freezes, and keeps wrap-around stall and flush counters for debug.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/hazard_unit.sv | 50 +++++
 rtl/id_ex_pipe.sv | 106 ++++++++++
 tb/tb_id_ex_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle bit positions and forward-select codes for the RV32I pipeline.
package pipe_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned RA_W   = 5;
   localparam int unsigned CTRL_W = 11;

   // Control bundle layout, MSB first
   localparam int unsigned CTRL_REG_WRITE  = 10;
   localparam int unsigned CTRL_MEM_READ   = 9;
   localparam int unsigned CTRL_MEM_WRITE  = 8;
   localparam int unsigned CTRL_MEM_TO_REG = 7;
   localparam int unsigned CTRL_ALU_SRC    = 6;
   localparam int unsigned CTRL_BRANCH     = 5;
   localparam int unsigned CTRL_JUMP       = 4;
   localparam int unsigned CTRL_ALU_OP_MSB = 3;
   localparam int unsigned CTRL_ALU_OP_LSB = 0;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use detection and next-cycle forward selects for the ID instruction.
module hazard_unit #(
   parameter int unsigned RA_W   = pipe_pkg::RA_W,
   parameter int unsigned CTRL_W = pipe_pkg::CTRL_W
) (
   input  logic              ex_valid,
   input  logic [CTRL_W-1:0] ex_ctrl,
   input  logic [RA_W-1:0]   ex_rd,
   input  logic              id_valid,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [RA_W-1:0]   exmem_rd,
   input  logic              exmem_reg_write,
   output logic              lu,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);
   import pipe_pkg::*;

   logic ex_writes;
   logic ex_loads;
   logic mem_writes;

   always_comb begin
      // x0 is excluded from every match so it never forwards or stalls
      ex_writes  = ex_valid & ex_ctrl[CTRL_REG_WRITE] & (ex_rd != '0);
      ex_loads   = ex_valid & ex_ctrl[CTRL_MEM_READ] & (ex_rd != '0);
      mem_writes = exmem_reg_write & (exmem_rd != '0);

      lu = ex_loads & id_valid &
           ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

      fwd_a = FWD_RF;
      if (ex_writes && id_rs1_used && (id_rs1 == ex_rd)) begin
         fwd_a = FWD_EXMEM;
      end else if (mem_writes && id_rs1_used && (id_rs1 == exmem_rd)) begin
         fwd_a = FWD_MEMWB;
      end

      fwd_b = FWD_RF;
      if (ex_writes && id_rs2_used && (id_rs2 == ex_rd)) begin
         fwd_b = FWD_EXMEM;
      end else if (mem_writes && id_rs2_used && (id_rs2 == exmem_rd)) begin
         fwd_b = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with load-use bubble insertion, flush/freeze handling,
// registered forward selects and wrap-around stall/flush debug counters.
module id_ex_pipe #(
   parameter int unsigned XLEN   = pipe_pkg::XLEN,
   parameter int unsigned RA_W   = pipe_pkg::RA_W,
   parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [RA_W-1:0]   id_rs1,
   input  logic [RA_W-1:0]   id_rs2,
   input  logic [RA_W-1:0]   id_rd,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              ex_flush,
   input  logic              mem_stall,
   input  logic [RA_W-1:0]   exmem_rd,
   input  logic              exmem_reg_write,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output logic [RA_W-1:0]   ex_rs1,
   output logic [RA_W-1:0]   ex_rs2,
   output logic [RA_W-1:0]   ex_rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [1:0]        ex_fwd_a,
   output logic [1:0]        ex_fwd_b,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);
   import pipe_pkg::*;

   logic       lu;
   logic [1:0] fwd_a_next;
   logic [1:0] fwd_b_next;
   logic       capture;

   hazard_unit #(
      .RA_W   (RA_W),
      .CTRL_W (CTRL_W)
   ) u_hazard_unit (
      .ex_valid        (ex_valid),
      .ex_ctrl         (ex_ctrl),
      .ex_rd           (ex_rd),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rs1_used     (id_rs1_used),
      .id_rs2_used     (id_rs2_used),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .lu              (lu),
      .fwd_a           (fwd_a_next),
      .fwd_b           (fwd_b_next)
   );

   assign hazard_stall = lu & ~ex_flush;
   // Anything other than a real, unflushed, unstalled instruction becomes an all-zero bubble
   assign capture      = id_valid & ~ex_flush & ~lu;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= '0;
         ex_fwd_a    <= FWD_RF;
         ex_fwd_b    <= FWD_RF;
         stall_count <= '0;
         flush_count <= '0;
      end else if (!mem_stall) begin
         ex_valid    <= capture;
         ex_pc       <= capture ? id_pc : '0;
         ex_rs1_data <= capture ? id_rs1_data : '0;
         ex_rs2_data <= capture ? id_rs2_data : '0;
         ex_imm      <= capture ? id_imm : '0;
         ex_rs1      <= capture ? id_rs1 : '0;
         ex_rs2      <= capture ? id_rs2 : '0;
         ex_rd       <= capture ? id_rd : '0;
         ex_ctrl     <= capture ? id_ctrl : '0;
         ex_fwd_a    <= capture ? fwd_a_next : FWD_RF;
         ex_fwd_b    <= capture ? fwd_b_next : FWD_RF;
         if (ex_flush) begin
            flush_count <= flush_count + CNT_W'(1);
         end else if (lu) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus randomized traffic
// compared against a behavioural model of the ID->EX register.
module tb_id_ex_pipe;
   import pipe_pkg::*;

   localparam logic [10:0] C_LW  = 11'h6C0;  // reg_write, mem_read, mem_to_reg, alu_src
   localparam logic [10:0] C_ADD = 11'h400;
   localparam logic [10:0] C_SUB = 11'h401;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid, id_rs1_used, id_rs2_used, ex_flush, mem_stall, exmem_reg_write;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd;
   logic [10:0] id_ctrl;
   logic        hazard_stall, ex_valid;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [10:0] ex_ctrl;
   logic [1:0]  ex_fwd_a, ex_fwd_b;
   logic [15:0] stall_count, flush_count;

   // Reference model of the EX-stage view
   logic        m_valid;
   logic [31:0] m_pc, m_d1, m_d2, m_imm;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [10:0] m_ctrl;
   logic [1:0]  m_fa, m_fb;
   logic [15:0] m_sc, m_fc;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_pipe dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_ctrl(id_ctrl),
      .ex_flush(ex_flush), .mem_stall(mem_stall), .exmem_rd(exmem_rd),
      .exmem_reg_write(exmem_reg_write), .hazard_stall(hazard_stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   function automatic logic model_lu();
      logic hit1, hit2;
      hit1 = id_rs1_used && (id_rs1 == m_rd);
      hit2 = id_rs2_used && (id_rs2 == m_rd);
      return m_valid && m_ctrl[CTRL_MEM_READ] && (m_rd != 5'd0) && id_valid && (hit1 || hit2);
   endfunction

   function automatic logic [1:0] model_fwd(input logic used, input logic [4:0] rs);
      if (used && rs != 5'd0 && m_valid && m_ctrl[CTRL_REG_WRITE] && m_rd == rs) return 2'b10;
      if (used && rs != 5'd0 && exmem_reg_write && exmem_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_clear(input logic clr_counts);
      {m_valid, m_pc, m_d1, m_d2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl, m_fa, m_fb} = '0;
      if (clr_counts) begin
         m_sc = '0;
         m_fc = '0;
      end
   endtask

   // Advance one clock, applying the priority rules to the model
   task automatic step();
      logic lu_now;
      logic [1:0] fa, fb;
      @(posedge clk);
      lu_now = model_lu();
      fa = model_fwd(id_rs1_used, id_rs1);
      fb = model_fwd(id_rs2_used, id_rs2);
      if (!mem_stall) begin
         if (ex_flush) begin
            model_clear(1'b0);
            m_fc = m_fc + 16'd1;
         end else if (lu_now) begin
            model_clear(1'b0);
            m_sc = m_sc + 16'd1;
         end else if (!id_valid) begin
            model_clear(1'b0);
         end else begin
            m_valid = 1'b1; m_pc = id_pc; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
            m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_ctrl = id_ctrl; m_fa = fa; m_fb = fb;
         end
      end
      @(negedge clk);
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic u1, input logic u2,
                           input logic [10:0] ctrl);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rs1_used = u1; id_rs2_used = u2; id_ctrl = ctrl;
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
   endtask

   task automatic test_reset();
      reset = 1'b0; ex_flush = 1'b0; mem_stall = 1'b0;
      exmem_rd = 5'd3; exmem_reg_write = 1'b1;
      drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_LW);
      model_clear(1'b1);
      repeat (3) @(negedge clk);
      checks++;
      if ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl,
           ex_fwd_a, ex_fwd_b, stall_count, flush_count, hazard_stall} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: ex_valid=%0b ex_pc=%h ctrl=%h sc=%0d fc=%0d hs=%0b, required all 0",
                  ex_valid, ex_pc, ex_ctrl, stall_count, flush_count, hazard_stall);
      end
      reset = 1'b1;
      exmem_reg_write = 1'b0;
      drive_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, C_ADD);
      id_pc = 32'h100;
      step();
      checks++;
      if (ex_pc !== 32'h100 || ex_valid !== 1'b1) begin
         failures++;
         $display("FAIL first_capture: ex_pc=%h ex_valid=%0b, required 00000100 / 1", ex_pc, ex_valid);
      end
   endtask

   task automatic test_load_use();
      logic [15:0] sc0;
      exmem_reg_write = 1'b0;
      drive_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);   // lw x5
      step();
      sc0 = m_sc;
      drive_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, C_ADD);  // add x6,x5,x1
      #1;
      checks++;
      if (hazard_stall !== 1'b1) begin
         failures++;
         $display("FAIL lu_stall: hazard_stall=%0b, required 1", hazard_stall);
      end
      step();
      checks++;
      if (ex_valid !== 1'b0 || stall_count !== sc0 + 16'd1 || ex_ctrl !== 11'd0) begin
         failures++;
         $display("FAIL lu_bubble: ex_valid=%0b ctrl=%h sc=%0d, required 0 / 000 / %0d",
                  ex_valid, ex_ctrl, stall_count, sc0 + 16'd1);
      end
      exmem_rd = 5'd5; exmem_reg_write = 1'b1;               // load now in MEM
      #1;
      checks++;
      if (hazard_stall !== 1'b0) begin
         failures++;
         $display("FAIL lu_release: hazard_stall=%0b, required 0", hazard_stall);
      end
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_fwd_a !== 2'b01 || ex_fwd_b !== 2'b00) begin
         failures++;
         $display("FAIL lu_capture: valid=%0b rd=%0d fa=%b fb=%b, required 1 / 6 / 01 / 00",
                  ex_valid, ex_rd, ex_fwd_a, ex_fwd_b);
      end
   endtask

   task automatic test_ex_forward();
      for (int r = 0; r < 2; r++) begin
         logic [4:0] dst;
         dst = (r == 0) ? 5'd3 : 5'd0;
         exmem_reg_write = 1'b0; exmem_rd = 5'd0;
         drive_id(1'b1, 5'd1, 5'd2, dst, 1'b1, 1'b1, C_ADD);   // add xdst
         step();
         drive_id(1'b1, 5'd1, dst, 5'd4, 1'b1, 1'b1, C_SUB);   // sub x4,x1,xdst
         step();
         checks++;
         if (ex_fwd_a !== 2'b00 || ex_fwd_b !== ((r == 0) ? 2'b10 : 2'b00)) begin
            failures++;
            $display("FAIL ex_fwd_rd%0d: fa=%b fb=%b, required 00 / %b",
                     dst, ex_fwd_a, ex_fwd_b, (r == 0) ? 2'b10 : 2'b00);
         end
      end
   endtask

   task automatic test_flush_lu();
      logic [15:0] sc0, fc0;
      exmem_reg_write = 1'b0;
      drive_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, C_LW);
      step();
      sc0 = m_sc; fc0 = m_fc;
      drive_id(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, C_ADD);
      ex_flush = 1'b1;
      #1;
      checks++;
      if (hazard_stall !== 1'b0) begin
         failures++;
         $display("FAIL flush_lu_hs: hazard_stall=%0b, required 0", hazard_stall);
      end
      step();
      ex_flush = 1'b0;
      checks++;
      if (ex_valid !== 1'b0 || flush_count !== fc0 + 16'd1 || stall_count !== sc0) begin
         failures++;
         $display("FAIL flush_lu: valid=%0b fc=%0d sc=%0d, required 0 / %0d / %0d",
                  ex_valid, flush_count, stall_count, fc0 + 16'd1, sc0);
      end
   endtask

   task automatic test_mem_stall();
      drive_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, C_LW);
      id_pc = 32'hCAFE0000;
      step();
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_id(1'b1, 5'd9, 5'd1, 5'd10, 1'b1, 1'b0, C_ADD);
         ex_flush = (i == 1);
         #1;
         checks++;
         if (hazard_stall !== (i != 1)) begin
            failures++;
            $display("FAIL mem_stall_hs%0d: hazard_stall=%0b, required %0b", i, hazard_stall, i != 1);
         end
         step();
         checks++;
         if (ex_pc !== 32'hCAFE0000 || ex_valid !== 1'b1 || ex_rd !== 5'd9 ||
             stall_count !== m_sc || flush_count !== m_fc) begin
            failures++;
            $display("FAIL mem_stall_hold%0d: pc=%h valid=%0b rd=%0d sc=%0d fc=%0d, required cafe0000 / 1 / 9 / %0d / %0d",
                     i, ex_pc, ex_valid, ex_rd, stall_count, flush_count, m_sc, m_fc);
         end
      end
      mem_stall = 1'b0; ex_flush = 1'b0;
      drive_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, C_ADD);
      id_pc = 32'h0000BEEF;
      step();
      checks++;
      if (ex_pc !== 32'h0000BEEF || ex_rd !== 5'd11 || ex_valid !== 1'b1) begin
         failures++;
         $display("FAIL mem_stall_resume: pc=%h rd=%0d valid=%0b, required 0000beef / 11 / 1",
                  ex_pc, ex_rd, ex_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 11'($urandom));
         ex_flush = ($urandom_range(0, 7) == 0);
         mem_stall = ($urandom_range(0, 7) == 0);
         exmem_rd = 5'($urandom_range(0, 3));
         exmem_reg_write = 1'($urandom);
         #1;
         checks++;
         if (hazard_stall !== (model_lu() && !ex_flush)) begin
            failures++;
            $display("FAIL rand_hs%0d: hazard_stall=%0b, required %0b", i, hazard_stall,
                     model_lu() && !ex_flush);
         end
         step();
         checks++;
         if ({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_fwd_a, ex_fwd_b} !==
             {m_valid, m_rs1, m_rs2, m_rd, m_ctrl, m_fa, m_fb} ||
             {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} !== {m_pc, m_d1, m_d2, m_imm} ||
             stall_count !== m_sc || flush_count !== m_fc) begin
            failures++;
            $display("FAIL rand_state%0d: v=%0b rd=%0d ctrl=%h fa=%b fb=%b pc=%h sc=%0d fc=%0d, required v=%0b rd=%0d ctrl=%h fa=%b fb=%b pc=%h sc=%0d fc=%0d",
                     i, ex_valid, ex_rd, ex_ctrl, ex_fwd_a, ex_fwd_b, ex_pc, stall_count,
                     flush_count, m_valid, m_rd, m_ctrl, m_fa, m_fb, m_pc, m_sc, m_fc);
         end
      end
      ex_flush = 1'b0; mem_stall = 1'b0;
   endtask

   task automatic test_counter_wrap();
      // Asynchronous reset landing between clock edges
      #2 reset = 1'b0;
      #1;
      checks++;
      if (stall_count !== 16'd0 || flush_count !== 16'd0 || ex_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: sc=%0d fc=%0d valid=%0b, required 0 / 0 / 0",
                  stall_count, flush_count, ex_valid);
      end
      model_clear(1'b1);
      @(negedge clk);
      reset = 1'b1;
      ex_flush = 1'b1;
      for (int i = 0; i < 65535; i++) step();
      checks++;
      if (flush_count !== 16'hFFFF || m_fc !== 16'hFFFF) begin
         failures++;
         $display("FAIL flush_count_max: fc=%h, required ffff", flush_count);
      end
      step();
      ex_flush = 1'b0;
      checks++;
      if (flush_count !== 16'd0 || stall_count !== 16'd0) begin
         failures++;
         $display("FAIL flush_count_wrap: fc=%0d sc=%0d, required 0 / 0", flush_count, stall_count);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_ex_forward();
      test_flush_lu();
      test_mem_stall();
      test_random();
      test_counter_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
